// File: rtl/operand_stack.sv
// ---------------------------------------------------------------------------
// operand_stack
//   LIFO operand store for the control FSM. A rising edge on `trigger` starts
//   one operation: push (`push`=1, stores `wrdata`) or pop (`push`=0, returns
//   the top word on `rddata`). Each operation finishes with a one-cycle `done`
//   pulse. On a pop, `rddata` is valid in the `done` cycle and holds its value
//   afterwards. Pushing while full and popping while empty leave the stack
//   unchanged and raise the sticky `overflow` / `underflow` flags.
//
// Build option:
//   STACK_FASTPOP_EN  defined     : combinational array read, so a pop
//                                   completes in one cycle like a push.
//                     not defined : synchronous-read array (block RAM), so a
//                                   pop passes through RD and takes two cycles.
//
// Ports:
//   clk        in   1        system clock
//   rst        in   1        synchronous active-high reset
//   trigger    in   1        operation request, rising edge starts one op
//   push       in   1        1 = push, 0 = pop (sampled with the trigger edge)
//   wrdata     in   WIDTH    push data (sampled with the trigger edge)
//   rddata     out  WIDTH    popped word, valid while done=1, held after
//   done       out  1        one-cycle completion pulse
//   count      out  AW+1     current occupancy, 0..DEPTH
//   empty      out  1        count == 0
//   full       out  1        count == DEPTH
//   overflow   out  1        sticky: push attempted while full
//   underflow  out  1        sticky: pop attempted while empty
//   dbg_state  out  2        FSM state (0 = IDLE, 1 = RD, 2 = ACK)
//
// Handshake: control raises `trigger`; the stack samples only the rising edge
// and only while idle. `done` is high for exactly one cycle, and that cycle is
// the last busy one, so an edge that becomes visible in the following cycle
// starts the next operation immediately. Edges seen while busy are dropped.
// ---------------------------------------------------------------------------
module operand_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrdata,
    output logic [WIDTH-1:0]         rddata,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_sp;
    logic             r_trig_q;
    logic [WIDTH-1:0] r_rddata;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_start;
    logic             w_empty;
    logic             w_full;
    logic [AW:0]      w_sp_m1;

`ifndef STACK_FASTPOP_EN
    // Registered read address and a flag telling RD whether the pop was real
    // (an underflowing pop returns zero instead of array data).
    logic [AW-1:0]    r_rd_addr;
    logic             r_pop_ok;
`endif

    // The pointer is one bit wider than the array index, so it never wraps
    // and full/empty come straight from its value.
    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == (AW+1)'(DEPTH));
    assign w_sp_m1 = r_sp - 1'b1;

    // Rising edge of trigger, accepted only while idle.
    assign w_start = trigger & ~r_trig_q & (r_state == IDLE);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
`ifdef STACK_FASTPOP_EN
                    w_next = ACK;
`else
                    w_next = push ? ACK : RD;
`endif
                end
            end
            RD:      w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pointer, flags, read data
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_trig_q    <= 1'b0;
            r_rddata    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`ifndef STACK_FASTPOP_EN
            r_rd_addr   <= '0;
            r_pop_ok    <= 1'b0;
`endif
        end else begin
            r_trig_q <= trigger;
            if (w_start) begin
                if (push) begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_sp <= r_sp + 1'b1;
                    end
                end else begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
`ifdef STACK_FASTPOP_EN
                        r_rddata    <= '0;
`else
                        r_pop_ok    <= 1'b0;
`endif
                    end else begin
                        r_sp <= w_sp_m1;
`ifdef STACK_FASTPOP_EN
                        r_rddata  <= r_mem[w_sp_m1[AW-1:0]];
`else
                        r_rd_addr <= w_sp_m1[AW-1:0];
                        r_pop_ok  <= 1'b1;
`endif
                    end
                end
            end
`ifndef STACK_FASTPOP_EN
            // Synchronous read: address was registered in the start cycle.
            if (r_state == RD) begin
                r_rddata <= r_pop_ok ? r_mem[r_rd_addr] : '0;
            end
`endif
        end
    end

    // Array storage is never cleared; only the pointer defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_start && push && !w_full) begin
            r_mem[r_sp[AW-1:0]] <= wrdata;
        end
    end

    assign rddata    = r_rddata;
    assign done      = (r_state == ACK);
    assign count     = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

`ifdef STACK_FASTPOP_EN
  localparam int POP_LAT = 1;
`else
  localparam int POP_LAT = 2;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             trigger = 1'b0;
  logic             push    = 1'b0;
  logic [WIDTH-1:0] wrdata  = '0;
  logic [WIDTH-1:0] rddata;
  logic             done;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic [1:0]       dbg_state;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .push      (push),
    .wrdata    (wrdata),
    .rddata    (rddata),
    .done      (done),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .dbg_state (dbg_state)
  );

  // scoreboard and reference model
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_stk[$];
  logic             m_ovf     = 1'b0;
  logic             m_unf     = 1'b0;
  logic [WIDTH-1:0] m_last_rd = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"},     64'(count),     64'(model_stk.size()));
    chk({tag, "_empty"},     64'(empty),     64'(model_stk.size() == 0));
    chk({tag, "_full"},      64'(full),      64'(model_stk.size() == DEPTH));
    chk({tag, "_overflow"},  64'(overflow),  64'(m_ovf));
    chk({tag, "_underflow"}, 64'(underflow), 64'(m_unf));
  endtask

  task automatic model_reset();
    model_stk.delete();
    exp_q.delete();
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    m_last_rd = '0;
  endtask

  // Apply the model effect of an accepted operation.
  task automatic model_op(input logic p, input logic [WIDTH-1:0] d);
    if (p) begin
      if (model_stk.size() < DEPTH) model_stk.push_back(d);
      else m_ovf = 1'b1;
    end else begin
      if (model_stk.size() > 0) m_last_rd = model_stk.pop_back();
      else begin
        m_last_rd = '0;
        m_unf     = 1'b1;
      end
      exp_q.push_back(m_last_rd);
    end
  endtask

  // One operation. Called at a negedge with trigger low; returns at a negedge
  // one cycle after done, with the stack idle again.
  task automatic do_op(input string tag, input logic p, input logic [WIDTH-1:0] d);
    int n;
    logic got;
    logic [WIDTH-1:0] e;
    trigger = 1'b1;
    push    = p;
    wrdata  = d;
    model_op(p, d);
    n   = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      @(negedge clk);
      n++;
      trigger = 1'b0;
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(n), p ? 64'd1 : 64'(POP_LAT));
    if (got && !p) begin
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk({tag, "_rddata"}, 64'(rddata), 64'(e));
      end
    end
    if (got && p) chk({tag, "_rddata_hold"}, 64'(rddata), 64'(m_last_rd));
    chk_status(tag);
    @(negedge clk);
    chk({tag, "_done_single"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dn;

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_done",   64'(done),      64'd0);
    chk("rst_rddata", 64'(rddata),    64'd0);
    chk("rst_state",  64'(dbg_state), 64'd0);
    chk_status("rst");

    // 1: basic push/pop
    do_op("t1_push5", 1'b1, 32'h0000_0005);
    do_op("t1_pushfe", 1'b1, 32'hFFFF_FFFE);
    chk("t1_count2", 64'(count), 64'd2);
    do_op("t1_pop1", 1'b0, '0);
    do_op("t1_pop2", 1'b0, '0);
    chk("t1_empty", 64'(empty), 64'd1);

    // 4: underflow from empty, then normal traffic keeps the flag
    do_op("t4_pop_empty", 1'b0, '0);
    chk("t4_unf", 64'(underflow), 64'd1);
    do_op("t4_push7", 1'b1, 32'd7);
    do_op("t4_pop7", 1'b0, '0);
    chk("t4_unf_sticky", 64'(underflow), 64'd1);

    // 3: fill, overflow, 9 never stored
    for (int i = 1; i <= DEPTH; i++) do_op("t3_fill", 1'b1, WIDTH'(i));
    chk("t3_full", 64'(full), 64'd1);
    do_op("t3_push9", 1'b1, 32'd9);
    chk("t3_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) do_op("t3_drain", 1'b0, '0);

    // random push/pop mix
    for (int i = 0; i < 30; i++) begin
      logic p;
      p = ($urandom_range(0, 99) < 55);
      do_op("rnd", p, WIDTH'($urandom));
    end
    while (model_stk.size() > 0) do_op("rnd_drain", 1'b0, '0);

    // 5: level-high trigger is one op
    trigger = 1'b1;
    push    = 1'b1;
    wrdata  = 32'h55;
    model_op(1'b1, 32'h55);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    trigger = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("t5_one_done", 64'(dn), 64'd1);
    chk_status("t5_held");

`ifndef STACK_FASTPOP_EN
    // 5b: edge that arrives while busy is dropped
    trigger = 1'b1;
    push    = 1'b0;
    model_op(1'b0, '0);
    @(negedge clk);
    chk("t5b_in_rd", 64'(dbg_state), 64'd1);
    trigger = 1'b0;
    @(negedge clk);
    chk("t5b_done", 64'(done), 64'd1);
    if (exp_q.size() > 0) chk("t5b_rddata", 64'(rddata), 64'(exp_q.pop_front()));
    push    = 1'b1;
    wrdata  = 32'hDEAD;
    trigger = 1'b1;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    trigger = 1'b0;
    @(negedge clk);
    chk("t5b_no_extra_done", 64'(dn), 64'd0);
    chk_status("t5b");
`endif

    // 6: reset in the middle of a pop
    do_op("t6_push11", 1'b1, 32'd11);
    trigger = 1'b1;
    push    = 1'b0;
`ifdef STACK_FASTPOP_EN
    rst = 1'b1;
    @(negedge clk);
`else
    @(negedge clk);
    chk("t6_in_rd", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    @(negedge clk);
`endif
    rst     = 1'b0;
    trigger = 1'b0;
    model_reset();
    chk("t6_state", 64'(dbg_state), 64'd0);
    chk("t6_rddata", 64'(rddata), 64'd0);
    dn = 0;
    repeat (4) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("t6_no_done", 64'(dn), 64'd0);
    chk_status("t6_after_rst");
    do_op("t6_push3", 1'b1, 32'd3);
    do_op("t6_pop3", 1'b0, '0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
